pixload: RTL

PIXLOAD -- requirements
Module: pixload

---
 rtl/pixload.sv | 95 +++++++++
 1 files changed

// File: rtl/pixload.sv
// Pixel loader: assembles bytes from a UART receive FIFO into 24-bit {R,G,B}
// pixels and writes them to consecutive pixel-memory addresses, one frame at a time.
module pixload #(
  parameter int ADDR_BITS   = 10,
  parameter int PIXEL_COUNT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_empty,
  input  logic [7:0]           r_data,
  output logic                 rd_uart,
  input  logic                 gray,
  input  logic                 restart,
  output logic                 we,
  output logic [ADDR_BITS-1:0] addr,
  output logic [23:0]          DI,
  output logic                 done
);

  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(PIXEL_COUNT - 1);

  typedef enum logic [1:0] {RECV, WRITE, DONE} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] idx;
  logic [1:0]           byte_cnt;
  logic [15:0]          pix_rg;

  // A restart cycle never pops, so a byte is not lost while the frame is re-armed.
  assign rd_uart = reset && (state == RECV) && !rx_empty && !restart;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RECV;
      idx      <= '0;
      byte_cnt <= '0;
      pix_rg   <= '0;
      we       <= 1'b0;
      done     <= 1'b0;
      addr     <= '0;
      DI       <= '0;
    end else if (restart) begin
      state    <= RECV;
      idx      <= '0;
      byte_cnt <= '0;
      we       <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        RECV: begin
          if (rd_uart) begin
            // gray only matters on the first byte; later bytes follow the 3-byte path
            if (byte_cnt == 2'd0 && gray) begin
              DI    <= {3{r_data}};
              addr  <= idx;
              we    <= 1'b1;
              state <= WRITE;
            end else if (byte_cnt == 2'd2) begin
              DI       <= {pix_rg, r_data};
              addr     <= idx;
              we       <= 1'b1;
              byte_cnt <= 2'd0;
              state    <= WRITE;
            end else begin
              if (byte_cnt == 2'd0) begin
                pix_rg[15:8] <= r_data;
              end else begin
                pix_rg[7:0] <= r_data;
              end
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          we <= 1'b0;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= RECV;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= RECV;
        end
      endcase
    end
  end

endmodule
